// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer/debounce filter bank.
//   MIN_SYNC_STAGES   : shortest legal synchronizer chain
//   MIN_FILTER_CYCLES : shortest legal persistence window
//   MIN_NUM_CH        : fewest legal channels
//   cnt_width()       : persistence counter width for a given window
package sync_pkg;

  localparam int unsigned MIN_SYNC_STAGES   = 2;
  localparam int unsigned MIN_FILTER_CYCLES = 1;
  localparam int unsigned MIN_NUM_CH        = 1;

  // Counter must be able to hold 0 .. filter_cycles; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned filter_cycles);
    int unsigned w;
    w = 32'($clog2(filter_cycles + 1));
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// Single input-conditioning channel: reset-to-constant synchronizer chain,
// run-length persistence filter and registered edge pulses.
//   clk        : system clock, rising edge
//   n_rst      : asynchronous active-low reset
//   async_in   : raw asynchronous input
//   sync_out   : last synchronizer stage
//   filt_out   : debounced level
//   rise_pulse : one-cycle pulse when filt_out goes 0->1
//   fall_pulse : one-cycle pulse when filt_out goes 1->0
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned          CNT_W    = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [SYNC_STAGES-1:0] CHAIN_RST = {SYNC_STAGES{RST_VAL}};

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_lvl;

  // Pure shift: stage0 only feeds stage1, keeping metastability confined.
  assign chain_d  = {chain_q[SYNC_STAGES-2:0], async_in};
  assign sync_lvl = chain_q[SYNC_STAGES-1];

  // Run-length filter: any return to the accepted level restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_lvl != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_lvl;
        cnt_d  = '0;
        rise_d = sync_lvl;
        fall_d = ~sync_lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State and outputs; reset loads the constant level with no pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chain_q <= CHAIN_RST;
      cnt_q   <= '0;
      filt_q  <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync_out   = sync_lvl;
  assign filt_out   = filt_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel boundary input conditioner: NUM_CH independent copies of
// synchronizer + persistence filter + edge detectors.
//   clk        : system clock, rising edge
//   n_rst      : asynchronous active-low reset
//   async_in   : [NUM_CH] raw asynchronous inputs
//   sync_out   : [NUM_CH] last synchronizer stage per channel
//   filt_out   : [NUM_CH] debounced levels
//   rise_pulse : [NUM_CH] one-cycle pulse on filt_out 0->1
//   fall_pulse : [NUM_CH] one-cycle pulse on filt_out 1->0
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int unsigned       NUM_CH        = 4,
  parameter int unsigned       SYNC_STAGES   = 2,
  parameter int unsigned       FILTER_CYCLES = 4,
  parameter logic [NUM_CH-1:0] RST_VAL       = '0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] filt_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  // Reject illegal configurations at elaboration.
  if (NUM_CH < MIN_NUM_CH) begin : g_bad_num_ch
    $error("sync_filter_bank: NUM_CH must be >= %0d", MIN_NUM_CH);
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("sync_filter_bank: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
  end
  if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter_cycles
    $error("sync_filter_bank: FILTER_CYCLES must be >= %0d", MIN_FILTER_CYCLES);
  end

  // One fully independent conditioner per channel.
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_VAL      (RST_VAL[i])
    ) u_ch (
      .clk       (clk),
      .n_rst     (n_rst),
      .async_in  (async_in[i]),
      .sync_out  (sync_out[i]),
      .filt_out  (filt_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed, table-driven bench for sync_filter_bank: a default 4-channel
// instance (RST_VAL=4'b0010) and a 1-channel SYNC_STAGES=3/FILTER_CYCLES=1 one.
module tb_sync_filter_bank;

  logic       clk;
  logic       n_rst;
  logic [3:0] ain;
  logic [3:0] sync_o, filt_o, rise_o, fall_o;
  logic [0:0] a2;
  logic [0:0] sync2, filt2, rise2, fall2;

  int total = 0;
  int bad   = 0;

  sync_filter_bank #(
    .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RST_VAL(4'b0010)
  ) dut (
    .clk(clk), .n_rst(n_rst), .async_in(ain),
    .sync_out(sync_o), .filt_out(filt_o),
    .rise_pulse(rise_o), .fall_pulse(fall_o)
  );

  sync_filter_bank #(
    .NUM_CH(1), .SYNC_STAGES(3), .FILTER_CYCLES(1), .RST_VAL(1'b0)
  ) dut2 (
    .clk(clk), .n_rst(n_rst), .async_in(a2),
    .sync_out(sync2), .filt_out(filt2),
    .rise_pulse(rise2), .fall_pulse(fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] ain;
    logic [3:0] sync;
    logic [3:0] filt;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] s, input logic [3:0] f,
                         input logic [3:0] r, input logic [3:0] fl);
    chk({tag, ".sync"}, sync_o, s);
    chk({tag, ".filt"}, filt_o, f);
    chk({tag, ".rise"}, rise_o, r);
    chk({tag, ".fall"}, fall_o, fl);
  endtask

  initial begin
    int rise_cnt, fall_cnt, rise_at, fall_at, filt_hi, sync_hi;

    // Reset release, channel 1 falls; channel 0 rise; channel 2 glitch rejected.
    vecs[0]  = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[9]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[10] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[11] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    vecs[13] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vecs[14] = '{4'b0101, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vecs[15] = '{4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
    vecs[16] = '{4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
    vecs[17] = '{4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
    vecs[18] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vecs[19] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vecs[20] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    vecs[21] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};

    n_rst = 1'b0;
    ain   = 4'b0000;
    a2    = 1'b0;
    step();
    step();
    chk_all("reset", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    n_rst = 1'b1;
    #1;
    chk_all("release", 4'b0010, 4'b0010, 4'b0000, 4'b0000);

    for (int i = 0; i < 22; i++) begin
      ain = vecs[i].ain;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].sync, vecs[i].filt, vecs[i].rise, vecs[i].fall);
    end

    // Channel 3 held high for exactly the filter window: accepted and released.
    rise_cnt = 0; fall_cnt = 0; rise_at = 0; fall_at = 0; filt_hi = 0; sync_hi = 0;
    for (int n = 1; n <= 16; n++) begin
      ain = (n <= 4) ? 4'b1001 : 4'b0001;
      step();
      if (sync_o[3]) sync_hi++;
      if (filt_o[3]) filt_hi++;
      if (rise_o[3]) begin rise_cnt++; rise_at = n; end
      if (fall_o[3]) begin fall_cnt++; fall_at = n; end
      chk($sformatf("ch3_both_pulses_n%0d", n), {3'b000, rise_o[3] & fall_o[3]}, 4'b0000);
    end
    chk("ch3_sync_hi_cycles", 4'(sync_hi), 4'd4);
    chk("ch3_filt_hi_cycles", 4'(filt_hi), 4'd4);
    chk("ch3_rise_count",     4'(rise_cnt), 4'd1);
    chk("ch3_fall_count",     4'(fall_cnt), 4'd1);
    chk("ch3_rise_edge",      4'(rise_at), 4'd6);
    chk("ch3_fall_edge",      4'(fall_at), 4'd10);

    // Channel 0 mid-count, then reset: outputs snap to RST_VAL immediately.
    ain = 4'b0000;
    for (int n = 1; n <= 4; n++) step();
    chk_all("midcount", 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    n_rst = 1'b0;
    #1;
    chk_all("midcount_rst", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    ain = 4'b0001;
    step();
    step();
    chk_all("in_rst", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    n_rst = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      chk_all($sformatf("rerel_n%0d", n),
              (n >= 2) ? 4'b0001 : 4'b0010,
              (n >= 6) ? 4'b0001 : 4'b0010,
              (n == 6) ? 4'b0001 : 4'b0000,
              (n == 6) ? 4'b0010 : 4'b0000);
    end

    // Three-stage chain, one-cycle filter: rise, fall, then a one-cycle glitch.
    a2 = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk($sformatf("sw_up_sync_n%0d", n), {3'b000, sync2}, (n >= 3) ? 4'd1 : 4'd0);
      chk($sformatf("sw_up_filt_n%0d", n), {3'b000, filt2}, (n >= 4) ? 4'd1 : 4'd0);
      chk($sformatf("sw_up_rise_n%0d", n), {3'b000, rise2}, (n == 4) ? 4'd1 : 4'd0);
      chk($sformatf("sw_up_fall_n%0d", n), {3'b000, fall2}, 4'd0);
    end
    a2 = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk($sformatf("sw_dn_sync_n%0d", n), {3'b000, sync2}, (n < 3) ? 4'd1 : 4'd0);
      chk($sformatf("sw_dn_filt_n%0d", n), {3'b000, filt2}, (n < 4) ? 4'd1 : 4'd0);
      chk($sformatf("sw_dn_rise_n%0d", n), {3'b000, rise2}, 4'd0);
      chk($sformatf("sw_dn_fall_n%0d", n), {3'b000, fall2}, (n == 4) ? 4'd1 : 4'd0);
    end
    for (int n = 1; n <= 6; n++) begin
      a2 = (n == 1) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("sw_gl_sync_n%0d", n), {3'b000, sync2}, (n == 3) ? 4'd1 : 4'd0);
      chk($sformatf("sw_gl_filt_n%0d", n), {3'b000, filt2}, (n == 4) ? 4'd1 : 4'd0);
      chk($sformatf("sw_gl_rise_n%0d", n), {3'b000, rise2}, (n == 4) ? 4'd1 : 4'd0);
      chk($sformatf("sw_gl_fall_n%0d", n), {3'b000, fall2}, (n == 5) ? 4'd1 : 4'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
